// File: rtl/dispatch_queue_pkg.sv
// Shared definitions for the dispatch queue: opcode encodings, the default
// ROB-tag width and its "operand ready" value, and the opcode classification
// helpers used to steer and rename dispatched instructions.
package dispatch_queue_pkg;

    localparam int DQ_OP_W  = 6;
    localparam int DQ_TAG_W = 4;
    // All-ones tag marks an operand whose value is already available.
    localparam logic [DQ_TAG_W-1:0] DQ_NO_TAG = 4'hF;

    typedef enum logic [DQ_OP_W-1:0] {
        OP_LUI   = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL   = 6'd3,  OP_JALR  = 6'd4,
        OP_BEQ   = 6'd5,  OP_BNE   = 6'd6,  OP_BLT   = 6'd7,  OP_BGE   = 6'd8,
        OP_BLTU  = 6'd9,  OP_BGEU  = 6'd10,
        OP_LB    = 6'd11, OP_LH    = 6'd12, OP_LW    = 6'd13, OP_LBU   = 6'd14,
        OP_LHU   = 6'd15,
        OP_SB    = 6'd16, OP_SH    = 6'd17, OP_SW    = 6'd18,
        OP_ADDI  = 6'd19, OP_SLTI  = 6'd20, OP_SLTIU = 6'd21, OP_XORI  = 6'd22,
        OP_ORI   = 6'd23, OP_ANDI  = 6'd24, OP_SLLI  = 6'd25, OP_SRLI  = 6'd26,
        OP_SRAI  = 6'd27,
        OP_ADD   = 6'd28, OP_SUB   = 6'd29, OP_SLL   = 6'd30, OP_SLT   = 6'd31,
        OP_SLTU  = 6'd32, OP_XOR   = 6'd33, OP_SRL   = 6'd34, OP_SRA   = 6'd35,
        OP_OR    = 6'd36, OP_AND   = 6'd37
    } op_e;

    // Operand-shape class: decides which operands come from the regfile and
    // which are replaced by pc/imm/constants.
    typedef enum logic [2:0] {
        CLS_BAD    = 3'd0,  // unrecognised opcode
        CLS_REG    = 3'd1,  // R-type ALU: rs1, rs2
        CLS_IMM    = 3'd2,  // I-type ALU, jalr, loads: rs1, imm
        CLS_LUI    = 3'd3,
        CLS_AUIPC  = 3'd4,
        CLS_JAL    = 3'd5,
        CLS_BRANCH = 3'd6,  // rs1, rs2, no rename
        CLS_STORE  = 3'd7   // rs1, rs2, imm on d_imm, no rename
    } op_class_e;

    function automatic op_class_e op_class(input logic [DQ_OP_W-1:0] op);
        op_class_e cls;
        case (op)
            OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
            OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND:           cls = CLS_REG;
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI,
            OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI, OP_JALR,
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:             cls = CLS_IMM;
            OP_LUI:                                          cls = CLS_LUI;
            OP_AUIPC:                                        cls = CLS_AUIPC;
            OP_JAL:                                          cls = CLS_JAL;
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: cls = CLS_BRANCH;
            OP_SB, OP_SH, OP_SW:                             cls = CLS_STORE;
            default:                                         cls = CLS_BAD;
        endcase
        return cls;
    endfunction

    // Memory operations go to the load/store buffer, everything else to the RS.
    function automatic logic is_lsb_op(input logic [DQ_OP_W-1:0] op);
        logic lsb;
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: lsb = 1'b1;
            default:             lsb = 1'b0;
        endcase
        return lsb;
    endfunction

    // Ops that produce a register result and therefore claim a rename slot.
    function automatic logic is_rename_op(input logic [DQ_OP_W-1:0] op);
        logic ren;
        case (op_class(op))
            CLS_BAD, CLS_BRANCH, CLS_STORE: ren = 1'b0;
            default:                        ren = 1'b1;
        endcase
        return ren;
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// Circular buffer holding decoded instructions between the decoder and the
// dispatch stage. Head entry is presented combinationally; clear empties it.
module issue_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [AW:0]   count_r;
    logic          push_s;
    logic          pop_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == (AW+1)'(0));
    assign count     = count_r;
    assign head_data = mem_r[head_r];
    assign push_s    = push && !full && !clear;
    assign pop_s     = pop && !empty && !clear;

    // Pointer and count bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {(AW+1){1'b0}};
        end else if (clear) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {(AW+1){1'b0}};
        end else begin
            if (push_s) tail_r <= tail_r + AW'(1);
            if (pop_s)  head_r <= head_r + AW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only meaningful between head and tail.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[tail_r] <= wdata;
    end

endmodule

// File: rtl/dispatch_queue.sv
// Dispatch stage: buffers decoded instructions, resolves the head entry's
// operands against the regfile and the CDB, and issues it to the ROB plus
// the RS or LSB with a rename write for result-producing ops.
module dispatch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int OP_W  = 6
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP_W-1:0]        in_op,
    input  logic [4:0]             in_rs1,
    input  logic [4:0]             in_rs2,
    input  logic [4:0]             in_rd,
    input  logic [XLEN-1:0]        in_imm,
    input  logic [XLEN-1:0]        in_pc,
    input  logic                   rob_full,
    input  logic                   rs_full,
    input  logic                   lsb_full,
    input  logic [TAG_W-1:0]       rob_tag,
    output logic [4:0]             rf_rs1,
    output logic [4:0]             rf_rs2,
    input  logic [TAG_W-1:0]       rf_tag1,
    input  logic [TAG_W-1:0]       rf_tag2,
    input  logic [XLEN-1:0]        rf_data1,
    input  logic [XLEN-1:0]        rf_data2,
    input  logic                   cdb_valid,
    input  logic [TAG_W-1:0]       cdb_tag,
    input  logic [XLEN-1:0]        cdb_data,
    output logic                   rob_o,
    output logic                   rs_o,
    output logic                   lsb_o,
    output logic [OP_W-1:0]        d_op,
    output logic [XLEN-1:0]        d_pc,
    output logic [XLEN-1:0]        d_imm,
    output logic [4:0]             d_rd,
    output logic [TAG_W-1:0]       d_rob_tag,
    output logic [TAG_W-1:0]       d_tag1,
    output logic [XLEN-1:0]        d_val1,
    output logic [TAG_W-1:0]       d_tag2,
    output logic [XLEN-1:0]        d_val2,
    output logic                   rn_we,
    output logic [4:0]             rn_addr,
    output logic [TAG_W-1:0]       rn_tag,
    output logic [$clog2(DEPTH):0] occupancy
);

    import dispatch_queue_pkg::*;

    // Width-generic form of the package's all-ones "ready" tag.
    localparam logic [TAG_W-1:0] NO_TAG = {TAG_W{1'b1}};
    localparam int EW = OP_W + 15 + 2 * XLEN;

    logic [EW-1:0]   head_data_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [OP_W-1:0] h_op_s;
    logic [4:0]      h_rs1_s;
    logic [4:0]      h_rs2_s;
    logic [4:0]      h_rd_s;
    logic [XLEN-1:0] h_imm_s;
    logic [XLEN-1:0] h_pc_s;
    op_class_e       head_cls_s;
    logic            head_lsb_s;
    logic            enq_s;
    logic            deq_s;
    logic            issue_s;
    logic            rename_s;
    logic [TAG_W-1:0] fwd1_tag_s, fwd2_tag_s, op1_tag_s, op2_tag_s;
    logic [XLEN-1:0]  fwd1_val_s, fwd2_val_s, op1_val_s, op2_val_s;

    issue_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk       (clk_in),
        .rst_n     (rst_in),
        .clear     (clear),
        .push      (enq_s),
        .pop       (deq_s),
        .wdata     ({in_op, in_rs1, in_rs2, in_rd, in_imm, in_pc}),
        .head_data (head_data_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (occupancy)
    );

    assign {h_op_s, h_rs1_s, h_rs2_s, h_rd_s, h_imm_s, h_pc_s} = head_data_s;

    assign in_ready   = !fifo_full_s;
    assign rf_rs1     = h_rs1_s;
    assign rf_rs2     = h_rs2_s;
    assign head_cls_s = op_class(h_op_s);
    assign head_lsb_s = is_lsb_op(h_op_s);

    assign enq_s    = in_valid && !fifo_full_s && rdy_in && !clear;
    // Unrecognised ops follow the RS path for back-pressure but issue nothing.
    assign deq_s    = !fifo_empty_s && rdy_in && !clear && !rob_full &&
                      (head_lsb_s ? !lsb_full : !rs_full);
    assign issue_s  = deq_s && (head_cls_s != CLS_BAD);
    assign rename_s = issue_s && is_rename_op(h_op_s) && (h_rd_s != 5'd0);

    // Capture a result broadcast in the same cycle the regfile still reports the tag.
    always_comb begin
        fwd1_tag_s = rf_tag1;
        fwd1_val_s = rf_data1;
        fwd2_tag_s = rf_tag2;
        fwd2_val_s = rf_data2;
        if (rf_tag1 != NO_TAG && cdb_valid && cdb_tag == rf_tag1) begin
            fwd1_tag_s = NO_TAG;
            fwd1_val_s = cdb_data;
        end else begin
            fwd1_tag_s = rf_tag1;
            fwd1_val_s = rf_data1;
        end
        if (rf_tag2 != NO_TAG && cdb_valid && cdb_tag == rf_tag2) begin
            fwd2_tag_s = NO_TAG;
            fwd2_val_s = cdb_data;
        end else begin
            fwd2_tag_s = rf_tag2;
            fwd2_val_s = rf_data2;
        end
    end

    // Replace register operands with pc/imm/constants according to op shape.
    always_comb begin
        op1_tag_s = fwd1_tag_s;
        op1_val_s = fwd1_val_s;
        op2_tag_s = fwd2_tag_s;
        op2_val_s = fwd2_val_s;
        case (head_cls_s)
            CLS_IMM: begin
                op2_tag_s = NO_TAG;
                op2_val_s = h_imm_s;
            end
            CLS_LUI: begin
                op1_tag_s = NO_TAG;
                op1_val_s = {XLEN{1'b0}};
                op2_tag_s = NO_TAG;
                op2_val_s = h_imm_s;
            end
            CLS_AUIPC: begin
                op1_tag_s = NO_TAG;
                op1_val_s = h_pc_s;
                op2_tag_s = NO_TAG;
                op2_val_s = h_imm_s;
            end
            CLS_JAL: begin
                op1_tag_s = NO_TAG;
                op1_val_s = h_pc_s;
                op2_tag_s = NO_TAG;
                op2_val_s = XLEN'(32'd4);
            end
            default: begin
                op1_tag_s = fwd1_tag_s;
                op1_val_s = fwd1_val_s;
                op2_tag_s = fwd2_tag_s;
                op2_val_s = fwd2_val_s;
            end
        endcase
    end

    // Registered dispatch outputs; strobes last exactly one cycle per issue.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rob_o     <= 1'b0;
            rs_o      <= 1'b0;
            lsb_o     <= 1'b0;
            rn_we     <= 1'b0;
            d_op      <= {OP_W{1'b0}};
            d_pc      <= {XLEN{1'b0}};
            d_imm     <= {XLEN{1'b0}};
            d_rd      <= 5'd0;
            d_rob_tag <= {TAG_W{1'b0}};
            d_tag1    <= NO_TAG;
            d_val1    <= {XLEN{1'b0}};
            d_tag2    <= NO_TAG;
            d_val2    <= {XLEN{1'b0}};
            rn_addr   <= 5'd0;
            rn_tag    <= {TAG_W{1'b0}};
        end else if (clear || !rdy_in) begin
            rob_o <= 1'b0;
            rs_o  <= 1'b0;
            lsb_o <= 1'b0;
            rn_we <= 1'b0;
        end else begin
            rob_o <= issue_s;
            rs_o  <= issue_s && !head_lsb_s;
            lsb_o <= issue_s && head_lsb_s;
            rn_we <= rename_s;
            if (issue_s) begin
                d_op      <= h_op_s;
                d_pc      <= h_pc_s;
                d_imm     <= h_imm_s;
                d_rd      <= h_rd_s;
                d_rob_tag <= rob_tag;
                d_tag1    <= op1_tag_s;
                d_val1    <= op1_val_s;
                d_tag2    <= op2_tag_s;
                d_val2    <= op2_val_s;
                rn_addr   <= h_rd_s;
                rn_tag    <= rob_tag;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_queue.sv
// Randomised and directed bench for dispatch_queue against a queue-based
// reference model of the dispatch rules.
module tb_dispatch_queue;
    import dispatch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int TAG_W = 4;
    localparam int OP_W  = 6;
    localparam logic [3:0] NT = 4'hF;

    logic clk_in, rst_in, rdy_in, clear, in_valid, in_ready;
    logic [5:0] in_op;
    logic [4:0] in_rs1, in_rs2, in_rd;
    logic [31:0] in_imm, in_pc;
    logic rob_full, rs_full, lsb_full;
    logic [3:0] rob_tag, rf_tag1, rf_tag2, cdb_tag;
    logic [4:0] rf_rs1, rf_rs2;
    logic [31:0] rf_data1, rf_data2, cdb_data;
    logic cdb_valid;
    logic rob_o, rs_o, lsb_o, rn_we;
    logic [5:0] d_op;
    logic [31:0] d_pc, d_imm, d_val1, d_val2;
    logic [4:0] d_rd, rn_addr;
    logic [3:0] d_rob_tag, d_tag1, d_tag2, rn_tag;
    logic [2:0] occupancy;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];
    int n_checks = 0;
    int n_fail   = 0;

    dispatch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm), .in_pc(in_pc),
        .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full), .rob_tag(rob_tag),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_tag1(rf_tag1), .rf_tag2(rf_tag2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .rob_o(rob_o), .rs_o(rs_o), .lsb_o(lsb_o),
        .d_op(d_op), .d_pc(d_pc), .d_imm(d_imm), .d_rd(d_rd), .d_rob_tag(d_rob_tag),
        .d_tag1(d_tag1), .d_val1(d_val1), .d_tag2(d_tag2), .d_val2(d_val2),
        .rn_we(rn_we), .rn_addr(rn_addr), .rn_tag(rn_tag), .occupancy(occupancy)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // 0 unknown, 1 reg-reg ALU, 2 reg-imm ALU/jalr, 3 load, 4 store, 5 branch, 6 lui, 7 auipc, 8 jal
    function automatic int kind(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND: return 1;
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI, OP_JALR: return 2;
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 3;
            OP_SB, OP_SH, OP_SW: return 4;
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: return 5;
            OP_LUI: return 6;
            OP_AUIPC: return 7;
            OP_JAL: return 8;
            default: return 0;
        endcase
    endfunction

    task automatic fwd(input logic [3:0] t, input logic [31:0] d, output logic [3:0] ot, output logic [31:0] ov);
        if (t != NT && cdb_valid && cdb_tag == t) begin
            ot = NT; ov = cdb_data;
        end else begin
            ot = t; ov = d;
        end
    endtask

    // One clock: check combinational outputs, predict, clock, check registered outputs.
    task automatic step();
        ent_t h, n;
        bit deq, enq, is_mem, x_rob, x_rs, x_lsb, x_rn;
        int k;
        logic [3:0] t1, t2, x_tag;
        logic [31:0] v1, v2;
        #1;
        chk("occupancy_pre", occupancy, q.size());
        chk("in_ready", in_ready, (q.size() < DEPTH));
        deq = 0; k = 0; is_mem = 0; x_rob = 0; x_rs = 0; x_lsb = 0; x_rn = 0;
        t1 = NT; t2 = NT; v1 = 0; v2 = 0;
        if (q.size() > 0) begin
            h = q[0];
            chk("rf_rs1", rf_rs1, h.rs1);
            chk("rf_rs2", rf_rs2, h.rs2);
            k = kind(h.op);
            is_mem = (k == 3 || k == 4);
            deq = rdy_in && !clear && !rob_full && (is_mem ? !lsb_full : !rs_full);
        end
        enq = in_valid && (q.size() < DEPTH) && rdy_in && !clear;
        n = '{in_op, in_rs1, in_rs2, in_rd, in_imm, in_pc};
        x_tag = rob_tag;
        if (deq && k != 0) begin
            x_rob = 1; x_lsb = is_mem; x_rs = !is_mem;
            x_rn = (k != 4 && k != 5 && h.rd != 5'd0);
            fwd(rf_tag1, rf_data1, t1, v1);
            fwd(rf_tag2, rf_data2, t2, v2);
            case (k)
                2, 3: begin t2 = NT; v2 = h.imm; end
                6: begin t1 = NT; v1 = 32'd0; t2 = NT; v2 = h.imm; end
                7: begin t1 = NT; v1 = h.pc;  t2 = NT; v2 = h.imm; end
                8: begin t1 = NT; v1 = h.pc;  t2 = NT; v2 = 32'd4; end
                default: ;
            endcase
        end
        @(posedge clk_in);
        #1;
        if (clear) q.delete();
        else begin
            if (deq) void'(q.pop_front());
            if (enq) q.push_back(n);
        end
        chk("rob_o", rob_o, x_rob);
        chk("rs_o", rs_o, x_rs);
        chk("lsb_o", lsb_o, x_lsb);
        chk("rn_we", rn_we, x_rn);
        if (x_rob) begin
            chk("d_op", d_op, h.op);
            chk("d_pc", d_pc, h.pc);
            chk("d_imm", d_imm, h.imm);
            chk("d_rd", d_rd, h.rd);
            chk("d_rob_tag", d_rob_tag, x_tag);
            chk("d_tag1", d_tag1, t1);
            chk("d_val1", d_val1, v1);
            chk("d_tag2", d_tag2, t2);
            chk("d_val2", d_val2, v2);
        end
        if (x_rn) begin
            chk("rn_addr", rn_addr, h.rd);
            chk("rn_tag", rn_tag, x_tag);
        end
        chk("occupancy", occupancy, q.size());
        @(negedge clk_in);
    endtask

    task automatic idle();
        in_valid = 0; clear = 0; rdy_in = 1; rob_full = 0; rs_full = 0; lsb_full = 0;
        cdb_valid = 0; cdb_tag = 4'd0; cdb_data = 32'd0; rob_tag = 4'd0;
        rf_tag1 = NT; rf_tag2 = NT; rf_data1 = 32'd0; rf_data2 = 32'd0;
    endtask

    task automatic put(input logic [5:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] pc);
        in_valid = 1; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_imm = imm; in_pc = pc;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 20 && q.size() > 0; i++) step();
        chk("drain_occupancy", occupancy, 64'd0);
    endtask

    initial begin
        idle();
        in_op = 6'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0; in_imm = 32'd0; in_pc = 32'd0;
        rst_in = 0;
        #12;
        chk("reset_rob_o", rob_o, 64'd0);
        chk("reset_rn_we", rn_we, 64'd0);
        chk("reset_occupancy", occupancy, 64'd0);
        chk("reset_d_tag1", d_tag1, 64'hF);
        chk("reset_d_tag2", d_tag2, 64'hF);
        chk("reset_in_ready", in_ready, 64'd1);
        @(negedge clk_in);
        rst_in = 1;

        // addi x5,x1,12
        put(OP_ADDI, 5'd1, 5'd0, 5'd5, 32'd12, 32'h40); step();
        idle(); rf_data1 = 32'd100; rob_tag = 4'd3; step();
        chk("addi_rob_o", rob_o, 64'd1);
        chk("addi_rs_o", rs_o, 64'd1);
        chk("addi_d_val1", d_val1, 64'd100);
        chk("addi_d_tag2", d_tag2, 64'hF);
        chk("addi_d_val2", d_val2, 64'd12);
        chk("addi_rn_we", rn_we, 64'd1);
        chk("addi_rn_addr", rn_addr, 64'd5);
        chk("addi_rn_tag", rn_tag, 64'd3);

        // lw with the RS full still goes; sw waits for the LSB
        put(OP_LW, 5'd2, 5'd0, 5'd6, 32'd8, 32'h44); rs_full = 1; step();
        idle(); rs_full = 1; step();
        chk("lw_lsb_o", lsb_o, 64'd1);
        chk("lw_rs_o", rs_o, 64'd0);
        put(OP_SW, 5'd3, 5'd4, 5'd0, 32'd16, 32'h48); lsb_full = 1; step();
        in_valid = 0; step(); step();
        chk("sw_held_lsb_o", lsb_o, 64'd0);
        chk("sw_held_occupancy", occupancy, 64'd1);
        lsb_full = 0; step();
        chk("sw_lsb_o", lsb_o, 64'd1);
        chk("sw_d_imm", d_imm, 64'd16);
        chk("sw_rn_we", rn_we, 64'd0);

        // fill to DEPTH, then dispatch and refill across the wrap
        idle(); rob_full = 1;
        for (int i = 0; i < 4; i++) begin
            put(OP_ADDI, 5'(i), 5'd0, 5'(i + 1), 32'(i), 32'(4 * i)); step();
        end
        chk("full_in_ready", in_ready, 64'd0);
        chk("full_occupancy", occupancy, 64'd4);
        put(OP_ORI, 5'd9, 5'd0, 5'd9, 32'd9, 32'h90); rob_full = 0; step();
        chk("full_deq_occupancy", occupancy, 64'd3);
        rob_full = 1; step();
        chk("wrap_refill_occupancy", occupancy, 64'd4);
        rob_full = 0; step();
        step();
        chk("enq_deq_occupancy", occupancy, 64'd3);
        drain();

        // CDB forwarding in the dispatch cycle
        put(OP_ADD, 5'd2, 5'd3, 5'd7, 32'd0, 32'h50); step();
        idle(); rf_tag1 = 4'd2; rf_data1 = 32'h1111; cdb_valid = 1; cdb_tag = 4'd2; cdb_data = 32'hDEAD; step();
        chk("cdb_d_tag1", d_tag1, 64'hF);
        chk("cdb_d_val1", d_val1, 64'hDEAD);

        // clear with 3 entries queued
        idle(); rob_full = 1;
        for (int i = 0; i < 3; i++) begin
            put(OP_ADD, 5'(i), 5'(i + 1), 5'(i + 2), 32'd0, 32'(i)); step();
        end
        chk("clear_pre_occupancy", occupancy, 64'd3);
        idle(); clear = 1; put(OP_ADDI, 5'd1, 5'd0, 5'd1, 32'd1, 32'd0); step();
        chk("clear_occupancy", occupancy, 64'd0);
        chk("clear_rob_o", rob_o, 64'd0);

        // reset in the middle of dispatching
        idle(); put(OP_ADDI, 5'd1, 5'd0, 5'd3, 32'd5, 32'h60); step();
        put(OP_ADDI, 5'd2, 5'd0, 5'd4, 32'd6, 32'h64); rob_tag = 4'd7; step();
        chk("prereset_rob_o", rob_o, 64'd1);
        idle(); rst_in = 0;
        #1;
        chk("midreset_rob_o", rob_o, 64'd0);
        chk("midreset_rs_o", rs_o, 64'd0);
        chk("midreset_rn_we", rn_we, 64'd0);
        chk("midreset_occupancy", occupancy, 64'd0);
        chk("midreset_d_tag1", d_tag1, 64'hF);
        chk("midreset_d_val1", d_val1, 64'd0);
        chk("midreset_d_rob_tag", d_rob_tag, 64'd0);
        chk("midreset_rn_addr", rn_addr, 64'd0);
        q.delete();
        @(negedge clk_in);
        rst_in = 1;

        // beq, addi x0, jal
        idle(); put(OP_BEQ, 5'd1, 5'd2, 5'd9, 32'd8, 32'h70); step();
        put(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd7, 32'h74); rob_tag = 4'd5; step();
        chk("beq_rob_o", rob_o, 64'd1);
        chk("beq_rn_we", rn_we, 64'd0);
        put(OP_JAL, 5'd0, 5'd0, 5'd1, 32'h20, 32'h100); step();
        chk("addi_x0_rob_o", rob_o, 64'd1);
        chk("addi_x0_rn_we", rn_we, 64'd0);
        idle(); rob_tag = 4'd6; step();
        chk("jal_d_val1", d_val1, 64'h100);
        chk("jal_d_val2", d_val2, 64'd4);
        chk("jal_rn_tag", rn_tag, 64'd6);

        // unrecognised opcode is dropped silently
        put(6'd63, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0); step();
        idle(); step();
        chk("bad_rob_o", rob_o, 64'd0);
        chk("bad_rn_we", rn_we, 64'd0);
        chk("bad_occupancy", occupancy, 64'd0);

        // rdy_in low freezes the queue
        put(OP_XOR, 5'd3, 5'd4, 5'd5, 32'd0, 32'h80); step();
        idle(); rdy_in = 0; step();
        chk("stall_rob_o", rob_o, 64'd0);
        chk("stall_occupancy", occupancy, 64'd1);
        rdy_in = 1; step();
        chk("unstall_rob_o", rob_o, 64'd1);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rdy_in    = ($urandom_range(0, 9) != 0);
            clear     = ($urandom_range(0, 49) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            in_op     = 6'($urandom_range(0, 40));
            in_rs1    = 5'($urandom);
            in_rs2    = 5'($urandom);
            in_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            in_imm    = $urandom;
            in_pc     = $urandom;
            rob_full  = ($urandom_range(0, 5) == 0);
            rs_full   = ($urandom_range(0, 3) == 0);
            lsb_full  = ($urandom_range(0, 3) == 0);
            rob_tag   = 4'($urandom);
            rf_tag1   = $urandom_range(0, 1) ? NT : 4'($urandom);
            rf_tag2   = $urandom_range(0, 1) ? NT : 4'($urandom);
            rf_data1  = $urandom;
            rf_data2  = $urandom;
            cdb_valid = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: cdb_tag = rf_tag1;
                1: cdb_tag = rf_tag2;
                default: cdb_tag = 4'($urandom);
            endcase
            cdb_data  = $urandom;
            step();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
